bim_updater: RTL and testbench

//  Write-side controller for the bimodal counter table. Accepts up to two resolved-branch

---
 rtl/bp_pkg.sv | 13 +
 rtl/bim_upd_fifo.sv | 58 +++++
 rtl/bim_updater.sv | 125 ++++++++++++
 tb/tb_bim_updater.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared definitions for the bimodal predictor write side.
package bp_pkg;

    localparam int unsigned BP_SET_IDX = 8;
    localparam int unsigned BP_CTR_W   = 2;
    localparam logic [BP_CTR_W-1:0] BP_CTR_MAX = '1;

    typedef struct packed {
        logic [BP_SET_IDX-1:0] idx;
        logic                  taken;
    } bim_upd_t;

endpackage

// File: rtl/bim_upd_fifo.sv
// Two-in / one-out circular queue of branch updates with occupancy and free>=2 flag.
module bim_upd_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = $bits(bim_upd_t)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [1:0]             push_n_i,
    input  logic [W-1:0]           push_a_i,
    input  logic [W-1:0]           push_b_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] occ_o,
    output logic                   free2_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] wr_ptr_b;
    logic [PTR_W:0]   occ_q, occ_d;

    // Next pointers/occupancy; power-of-2 depth makes pointer wrap implicit.
    always_comb begin
        wr_ptr_b = wr_ptr_q + PTR_W'(1);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
        wr_ptr_d = wr_ptr_q + PTR_W'(push_n_i);
        occ_d    = occ_q + (PTR_W+1)'(push_n_i) - (PTR_W+1)'(pop_i);
    end

    // Storage: older entry at the write pointer, younger one right after it.
    always_ff @(posedge clk) begin
        if (push_n_i != 2'd0) mem_q[wr_ptr_q] <= push_a_i;
        if (push_n_i == 2'd2) mem_q[wr_ptr_b] <= push_b_i;
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;
    assign free2_o = (occ_q <= (PTR_W+1)'(DEPTH - 2));

endmodule

// File: rtl/bim_updater.sv
// Bimodal counter table write-side controller: queue commit updates, drain one per cycle
// as read (stage R) / saturating update + write-back (stage W).
module bim_updater
    import bp_pkg::*;
#(
    parameter int unsigned SET_IDX = BP_SET_IDX,
    parameter int unsigned CTR_W   = BP_CTR_W,
    parameter int unsigned DEPTH   = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         upd_valid,
    input  logic [SET_IDX-1:0] upd_idx0,
    input  logic [SET_IDX-1:0] upd_idx1,
    input  logic [1:0]         upd_taken,
    output logic               upd_ready,
    output logic [SET_IDX-1:0] bim_raddr1,
    input  logic [CTR_W-1:0]   bim_rdata1,
    output logic               bim_we,
    output logic [SET_IDX-1:0] bim_waddr,
    output logic [CTR_W-1:0]   bim_wdata,
    output logic               busy,
    output logic [CNT_W-1:0]   upd_count
);

    typedef struct packed {
        logic [SET_IDX-1:0] idx;
        logic               taken;
    } upd_t;

    localparam int unsigned UPD_W = $bits(upd_t);
    localparam logic [CTR_W-1:0] CTR_TOP = '1;

    upd_t                 in_a, in_b, head;
    logic [1:0]           push_n;
    logic [$clog2(DEPTH):0] occ;
    logic                 free2;
    logic                 r_valid;
    logic [CTR_W-1:0]     old_ctr;
    logic [CTR_W-1:0]     w_new;

    logic                 w_valid_q, w_valid_d;
    logic [SET_IDX-1:0]   w_idx_q,   w_idx_d;
    logic                 w_taken_q, w_taken_d;
    logic [CTR_W-1:0]     w_old_q,   w_old_d;
    logic [CNT_W-1:0]     upd_count_q, upd_count_d;

    assign upd_ready = rst_n && free2;

    // Compact the valid commit slots so the older valid one is always pushed first.
    always_comb begin
        push_n = 2'd0;
        in_a   = '{idx: upd_idx0, taken: upd_taken[0]};
        in_b   = '{idx: upd_idx1, taken: upd_taken[1]};
        if (upd_ready) begin
            case (upd_valid)
                2'b01:   push_n = 2'd1;
                2'b10: begin
                    push_n = 2'd1;
                    in_a   = '{idx: upd_idx1, taken: upd_taken[1]};
                end
                2'b11:   push_n = 2'd2;
                default: push_n = 2'd0;
            endcase
        end
    end

    bim_upd_fifo #(
        .DEPTH (DEPTH),
        .W     (UPD_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push_n_i (push_n),
        .push_a_i (in_a),
        .push_b_i (in_b),
        .pop_i    (r_valid),
        .head_o   (head),
        .occ_o    (occ),
        .free2_o  (free2)
    );

    // Stage R: read head counter; the W-stage write has not landed yet, so forward it.
    always_comb begin
        r_valid    = rst_n && (occ != '0);
        bim_raddr1 = head.idx;
        old_ctr    = (w_valid_q && (w_idx_q == head.idx)) ? w_new : bim_rdata1;
        w_valid_d  = r_valid;
        w_idx_d    = head.idx;
        w_taken_d  = head.taken;
        w_old_d    = old_ctr;
    end

    // Stage W: saturating update, write suppressed when the counter does not change.
    always_comb begin
        if (w_taken_q) w_new = (w_old_q == CTR_TOP) ? w_old_q : w_old_q + CTR_W'(1);
        else           w_new = (w_old_q == '0)      ? w_old_q : w_old_q - CTR_W'(1);
        bim_we      = rst_n && w_valid_q && (w_new != w_old_q);
        bim_waddr   = w_idx_q;
        bim_wdata   = w_new;
        busy        = rst_n && ((occ != '0) || w_valid_q);
        upd_count_d = upd_count_q + CNT_W'(w_valid_q);
    end

    // W-stage and retired-update counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_valid_q   <= 1'b0;
            w_idx_q     <= '0;
            w_taken_q   <= 1'b0;
            w_old_q     <= '0;
            upd_count_q <= '0;
        end else begin
            w_valid_q   <= w_valid_d;
            w_idx_q     <= w_idx_d;
            w_taken_q   <= w_taken_d;
            w_old_q     <= w_old_d;
            upd_count_q <= upd_count_d;
        end
    end

    assign upd_count = upd_count_q;

endmodule

// File: tb/tb_bim_updater.sv
// Self-checking bench for bim_updater: table model + ordered-update reference model.
module tb_bim_updater;

    localparam int unsigned SET_IDX = 8;
    localparam int unsigned CTR_W   = 2;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 32;
    localparam int          CMAX    = (1 << CTR_W) - 1;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [1:0]         upd_valid = '0;
    logic [SET_IDX-1:0] upd_idx0 = '0;
    logic [SET_IDX-1:0] upd_idx1 = '0;
    logic [1:0]         upd_taken = '0;
    logic               upd_ready;
    logic [SET_IDX-1:0] bim_raddr1;
    logic [CTR_W-1:0]   bim_rdata1;
    logic               bim_we;
    logic [SET_IDX-1:0] bim_waddr;
    logic [CTR_W-1:0]   bim_wdata;
    logic               busy;
    logic [CNT_W-1:0]   upd_count;

    int checks = 0;
    int failures = 0;
    bit tb_init = 1'b1;

    bim_updater #(
        .SET_IDX (SET_IDX),
        .CTR_W   (CTR_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .upd_valid  (upd_valid),
        .upd_idx0   (upd_idx0),
        .upd_idx1   (upd_idx1),
        .upd_taken  (upd_taken),
        .upd_ready  (upd_ready),
        .bim_raddr1 (bim_raddr1),
        .bim_rdata1 (bim_rdata1),
        .bim_we     (bim_we),
        .bim_waddr  (bim_waddr),
        .bim_wdata  (bim_wdata),
        .busy       (busy),
        .upd_count  (upd_count)
    );

    always #5 clk = ~clk;

    function automatic int init_val(input int i);
        case (i)
            3:       return 2;
            5:       return 2;
            7:       return 3;
            9:       return 0;
            12:      return 1;
            default: return i % 4;
        endcase
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Counter table seen by the DUT: combinational read, write lands at clock edge.
    logic [CTR_W-1:0] tbl [256];
    assign bim_rdata1 = tbl[bim_raddr1];
    always @(posedge clk) begin
        if (tb_init) begin
            for (int i = 0; i < 256; i++) tbl[i] <= CTR_W'(init_val(i));
        end else if (bim_we) begin
            tbl[bim_waddr] <= bim_wdata;
        end
    end

    // Reference model: FIFO of accepted updates applied in commit order to a shadow table.
    typedef struct { int idx; int taken; } mupd_t;
    mupd_t       mq[$];
    mupd_t       e;
    int          ref_tbl [256];
    bit          model_on = 1'b0;
    bit          wv = 1'b0;
    bit          wchg = 1'b0;
    int          widx = 0;
    int          wnew = 0;
    int          old = 0;
    logic [31:0] cnt_m = '0;
    bit          exp_ready;

    always @(negedge clk) begin
        exp_ready = rst_n && ((int'(DEPTH) - mq.size()) >= 2);
        if (model_on) begin
            check("upd_ready", upd_ready, exp_ready);
            check("busy", busy, rst_n && (mq.size() > 0 || wv));
            check("bim_we", bim_we, rst_n && wv && wchg);
            if (rst_n && wv && wchg) begin
                check("bim_waddr", bim_waddr, widx);
                check("bim_wdata", bim_wdata, wnew);
            end
            check("upd_count", upd_count, cnt_m);
            if (rst_n && mq.size() > 0) check("bim_raddr1", bim_raddr1, mq[0].idx);
        end
        if (tb_init) for (int i = 0; i < 256; i++) ref_tbl[i] = init_val(i);
        if (!rst_n) begin
            mq.delete();
            wv       = 1'b0;
            cnt_m    = '0;
            model_on = 1'b1;
        end else if (model_on) begin
            if (wv) begin
                cnt_m        = cnt_m + 1;
                ref_tbl[widx] = wnew;
            end
            wv = 1'b0;
            if (mq.size() > 0) begin
                e   = mq.pop_front();
                old = ref_tbl[e.idx];
                if (e.taken != 0) wnew = (old == CMAX) ? CMAX : old + 1;
                else              wnew = (old == 0) ? 0 : old - 1;
                widx = e.idx;
                wchg = (wnew != old);
                wv   = 1'b1;
            end
            if (exp_ready) begin
                if (upd_valid[0]) mq.push_back('{int'(upd_idx0), int'(upd_taken[0])});
                if (upd_valid[1]) mq.push_back('{int'(upd_idx1), int'(upd_taken[1])});
            end
        end
    end

    task automatic drive(input logic [1:0] v, input int i0, input int i1, input logic [1:0] tk);
        upd_valid = v;
        upd_idx0  = SET_IDX'(i0);
        upd_idx1  = SET_IDX'(i1);
        upd_taken = tk;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(2'b00, 0, 0, 2'b00);
    endtask

    int nw;
    int k;
    int cyc;
    bit acc;
    bit saw_nr;

    initial begin
        // Reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", upd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_we", bim_we, 0);
        rst_n   = 1'b1;
        tb_init = 1'b0;
        #1;
        check("rst_count", upd_count, 0);
        check("post_rst_ready", upd_ready, 1);
        idle(1);

        // 1: idx5=10 taken -> write 11 two cycles later
        drive(2'b01, 5, 0, 2'b01);
        drive(2'b00, 0, 0, 2'b00);
        check("t1_we", bim_we, 1);
        check("t1_waddr", bim_waddr, 5);
        check("t1_wdata", bim_wdata, 2'b11);
        idle(2);
        check("t1_count", upd_count, 1);

        // 2: saturated updates retire without writing
        drive(2'b11, 7, 9, 2'b01);
        nw = 0;
        for (int i = 0; i < 4; i++) begin
            drive(2'b00, 0, 0, 2'b00);
            if (bim_we) nw++;
        end
        check("t2_nowrite", nw, 0);
        check("t2_count", upd_count, 3);

        // 3: same-index chain relies on forwarding
        drive(2'b01, 3, 0, 2'b01);
        drive(2'b01, 3, 0, 2'b00);
        check("t3_we0", bim_we, 1);
        check("t3_wdata0", bim_wdata, 2'b11);
        drive(2'b01, 3, 0, 2'b00);
        check("t3_wdata1", bim_wdata, 2'b10);
        drive(2'b00, 0, 0, 2'b00);
        check("t3_wdata2", bim_wdata, 2'b01);
        check("t3_waddr2", bim_waddr, 3);
        idle(2);
        check("t3_count", upd_count, 6);

        // 4: back-pressure with dual pushes every cycle, producer holds when not ready
        k = 0; cyc = 0; saw_nr = 0;
        while (k < 8 && cyc < 200) begin
            upd_valid = 2'b11;
            upd_idx0  = SET_IDX'(20 + (2 * k) % 3);
            upd_idx1  = SET_IDX'(20 + (2 * k + 1) % 3);
            upd_taken = (k % 3 == 0) ? 2'b11 : (k % 3 == 1) ? 2'b01 : 2'b10;
            acc = upd_ready;
            if (!upd_ready) saw_nr = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
            if (acc) k++;
        end
        check("t4_all_pushed", k, 8);
        check("t4_backpressure", saw_nr, 1);
        idle(8);
        check("t4_count", upd_count, 22);
        check("t4_idle_busy", busy, 0);

        // 5: reset with entries queued and one in flight
        drive(2'b11, 30, 31, 2'b11);
        drive(2'b11, 32, 33, 2'b00);
        rst_n     = 1'b0;
        upd_valid = 2'b00;
        #1;
        check("t5_rst_ready", upd_ready, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_we", bim_we, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("t5_we", bim_we, 0);
        check("t5_busy", busy, 0);
        check("t5_count", upd_count, 0);
        nw = 0;
        for (int i = 0; i < 6; i++) begin
            drive(2'b00, 0, 0, 2'b00);
            if (bim_we) nw++;
        end
        check("t5_nowrite", nw, 0);

        // 6: only slot 1 valid
        drive(2'b10, 40, 12, 2'b10);
        drive(2'b00, 0, 0, 2'b00);
        check("t6_we", bim_we, 1);
        check("t6_waddr", bim_waddr, 12);
        check("t6_wdata", bim_wdata, 2'b10);
        idle(3);
        check("t6_count", upd_count, 1);
        check("t6_slot0_untouched", tbl[40], 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
